// File: rtl/irq_pkg.sv
// Shared types and defaults for the interrupt service responder.
package irq_pkg;

  localparam int NUM_SRC    = 4;
  localparam int SRC_W      = 2;
  localparam int FIFO_DEPTH = 4;
  localparam int LEN_W      = 8;
  localparam int CNT_W      = 8;

  // One-hot FSM encoding; any other pattern is treated as illegal.
  typedef enum logic [2:0] {
    IDLE    = 3'b001,
    SERVICE = 3'b010,
    DONE    = 3'b100
  } state_t;

  // Index of the lowest set bit; returns 0 when no bit is set.
  function automatic logic [SRC_W-1:0] onehot_lowest(input logic [NUM_SRC-1:0] ack);
    logic [SRC_W-1:0] idx;
    idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (ack[i]) idx = SRC_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/irq_vec_fifo.sv
// Pending-grant queue: synchronous FIFO with wrap-bit pointers.
// A push while full is ignored; the parent decides how to flag it.
module irq_vec_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

  // Pointer advance on accepted push / pop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/irq_service_responder.sv
// CPU-side responder: captures granted vectors into a queue, services
// them one at a time with a down-counting timer, and pulses done.
//
// state   | meaning
// IDLE    | waiting; pops the queue head when one is pending
// SERVICE | timer running for active_vec
// DONE    | one-cycle completion pulse, serviced count bumped
module irq_service_responder
  import irq_pkg::*;
#(
  parameter int NUM_SRC    = irq_pkg::NUM_SRC,
  parameter int SRC_W      = irq_pkg::SRC_W,
  parameter int FIFO_DEPTH = irq_pkg::FIFO_DEPTH,
  parameter int LEN_W      = irq_pkg::LEN_W,
  parameter int CNT_W      = irq_pkg::CNT_W
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     irq,
  input  logic [NUM_SRC-1:0]       ack,
  input  logic [LEN_W-1:0]         svc_len,
  input  logic                     clr_flags,
  output logic                     done,
  output logic                     busy,
  output logic [SRC_W-1:0]         active_vec,
  output logic                     active_valid,
  output logic [NUM_SRC*CNT_W-1:0] svc_count,
  output logic                     ovf,
  output logic                     proto_err
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [LEN_W-1:0]   r_timer;
  logic [SRC_W-1:0]   r_active_vec;
  logic [CNT_W-1:0]   r_svc_cnt [NUM_SRC];
  logic               r_ovf;
  logic               r_proto_err;

  logic               w_grant;
  logic               w_multi;
  logic               w_proto_set;
  logic               w_ovf_set;
  logic               w_push;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  logic [SRC_W-1:0]   w_push_idx;
  logic [SRC_W-1:0]   w_head;

  // Capture: irq with a nonzero ack is a grant; malformed ack flags an error.
  assign w_grant     = irq && (ack != '0);
  assign w_multi     = (ack & (ack - NUM_SRC'(1))) != '0;
  assign w_proto_set = irq && ((ack == '0) || w_multi);
  assign w_push_idx  = onehot_lowest(ack);
  assign w_push      = w_grant && !w_full;
  assign w_ovf_set   = w_grant && w_full;
  assign w_pop       = (r_state == IDLE) && !w_empty;

  irq_vec_fifo #(
    .WIDTH (SRC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (w_push),
    .i_data  (w_push_idx),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Next-state decode; unknown encodings fall back to IDLE.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (!w_empty) w_state_nxt = SERVICE;
      SERVICE: if (r_timer == LEN_W'(1)) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // Service timer and active vector; a zero length still runs one cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_timer      <= '0;
      r_active_vec <= '0;
    end else if (w_pop) begin
      r_active_vec <= w_head;
      r_timer      <= (svc_len == '0) ? LEN_W'(1) : svc_len;
    end else if (r_state == SERVICE) begin
      r_timer <= r_timer - LEN_W'(1);
    end
  end

  // Per-source serviced counters, saturating at all-ones.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_SRC; i++) r_svc_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if ((r_state == DONE) && (r_active_vec == SRC_W'(i)) && (r_svc_cnt[i] != '1))
          r_svc_cnt[i] <= r_svc_cnt[i] + CNT_W'(1);
      end
    end
  end

  // Sticky flags; a set in the same cycle as a clear takes priority.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ovf       <= 1'b0;
      r_proto_err <= 1'b0;
    end else begin
      if (w_ovf_set)      r_ovf <= 1'b1;
      else if (clr_flags) r_ovf <= 1'b0;
      if (w_proto_set)    r_proto_err <= 1'b1;
      else if (clr_flags) r_proto_err <= 1'b0;
    end
  end

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_cnt_pack
    assign svc_count[g*CNT_W +: CNT_W] = r_svc_cnt[g];
  end

  // All outputs decode straight from registers.
  assign done         = (r_state == DONE);
  assign active_valid = (r_state == SERVICE) || (r_state == DONE);
  assign busy         = active_valid || !w_empty;
  assign active_vec   = r_active_vec;
  assign ovf          = r_ovf;
  assign proto_err    = r_proto_err;

endmodule

// File: tb/tb_irq_service_responder.sv
// Directed bench for irq_service_responder with hand-derived expectations.
module tb_irq_service_responder;

  logic        clk;
  logic        reset_n;
  logic        irq;
  logic [3:0]  ack;
  logic [7:0]  svc_len;
  logic        clr_flags;
  logic        done;
  logic        busy;
  logic [1:0]  active_vec;
  logic        active_valid;
  logic [31:0] svc_count;
  logic        ovf;
  logic        proto_err;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int done_cyc[$];
  int done_vec[$];

  irq_service_responder dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .irq          (irq),
    .ack          (ack),
    .svc_len      (svc_len),
    .clr_flags    (clr_flags),
    .done         (done),
    .busy         (busy),
    .active_vec   (active_vec),
    .active_valid (active_valid),
    .svc_count    (svc_count),
    .ovf          (ovf),
    .proto_err    (proto_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset_n && done) begin
      done_cyc.push_back(cyc);
      done_vec.push_back(int'(active_vec));
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] cnt(input int i);
    return svc_count[i*8 +: 8];
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  // One-cycle grant; returns at the negedge just after the capture edge.
  task automatic grant(input logic [3:0] a);
    step();
    irq = 1'b1;
    ack = a;
    step();
    irq = 1'b0;
    ack = 4'b0000;
  endtask

  task automatic wait_idle(input int max_cyc);
    int k;
    for (k = 0; k < max_cyc; k++) begin
      step();
      if (!busy) break;
    end
    if (k == max_cyc) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int n0;
    int exp_vec[5];
    reset_n   = 1'b1;
    irq       = 1'b0;
    ack       = 4'b0000;
    svc_len   = 8'd0;
    clr_flags = 1'b0;

    // 1: reset and quiet idle
    #2 reset_n = 1'b0;
    step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    step();
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_busy", 32'(busy), 32'd0);
    end
    chk("idle_outs", {done, active_valid, active_vec, ovf, proto_err}, 32'd0);
    chk("idle_cnt", svc_count, 32'd0);

    // 2: single grant, svc_len=3
    step();
    irq = 1'b1; ack = 4'b0100; svc_len = 8'd3;
    step();
    irq = 1'b0; ack = 4'b0000;
    chk("t2_e0_valid", 32'(active_valid), 32'd0);
    chk("t2_e0_busy", 32'(busy), 32'd1);
    step();
    chk("t2_e1_vec", 32'(active_vec), 32'd2);
    chk("t2_e1_valid", 32'(active_valid), 32'd1);
    chk("t2_e1_done", 32'(done), 32'd0);
    step();
    chk("t2_e2_done", 32'(done), 32'd0);
    step();
    chk("t2_e3_done", 32'(done), 32'd0);
    step();
    chk("t2_e4_done", 32'(done), 32'd1);
    chk("t2_e4_vec", 32'(active_vec), 32'd2);
    step();
    chk("t2_e5_done", 32'(done), 32'd0);
    chk("t2_cnt2", 32'(cnt(2)), 32'd1);
    chk("t2_busy", 32'(busy), 32'd0);
    chk("t2_valid", 32'(active_valid), 32'd0);

    // 3: two grants two cycles apart, svc_len=5
    svc_len = 8'd5;
    n0 = done_cyc.size();
    grant(4'b0001);
    grant(4'b1000);
    wait_idle(100);
    chk("t3_ndone", 32'(done_cyc.size() - n0), 32'd2);
    if (done_cyc.size() - n0 == 2) begin
      chk("t3_vec0", 32'(done_vec[n0]), 32'd0);
      chk("t3_vec1", 32'(done_vec[n0+1]), 32'd3);
      chk("t3_gap", 32'(done_cyc[n0+1] - done_cyc[n0]), 32'd7);
    end
    chk("t3_cnt0", 32'(cnt(0)), 32'd1);
    chk("t3_cnt3", 32'(cnt(3)), 32'd1);
    chk("t3_ovf", 32'(ovf), 32'd0);

    // 4: fill the queue, overflow, clear
    svc_len = 8'd20;
    n0 = done_cyc.size();
    exp_vec = '{0, 1, 2, 3, 0};
    step();
    irq = 1'b1; ack = 4'b0001;
    step();
    ack = 4'b0010;
    chk("t4_e0_ovf", 32'(ovf), 32'd0);
    step();
    ack = 4'b0100;
    chk("t4_e1_vec", 32'(active_vec), 32'd0);
    chk("t4_e1_valid", 32'(active_valid), 32'd1);
    step();
    ack = 4'b1000;
    step();
    ack = 4'b0001;
    step();
    chk("t4_e4_ovf", 32'(ovf), 32'd0);
    ack = 4'b0010;
    step();
    irq = 1'b0; ack = 4'b0000;
    chk("t4_e5_ovf", 32'(ovf), 32'd1);
    clr_flags = 1'b1;
    step();
    clr_flags = 1'b0;
    chk("t4_clr_ovf", 32'(ovf), 32'd0);
    chk("t4_proto", 32'(proto_err), 32'd0);
    wait_idle(1000);
    chk("t4_ndone", 32'(done_cyc.size() - n0), 32'd5);
    if (done_cyc.size() - n0 == 5) begin
      for (int k = 0; k < 5; k++) chk("t4_order", 32'(done_vec[n0+k]), 32'(exp_vec[k]));
    end
    chk("t4_cnt", svc_count, {8'd2, 8'd2, 8'd1, 8'd3});

    // 5: protocol cases
    svc_len = 8'd4;
    grant(4'b0110);
    chk("t5_multi_perr", 32'(proto_err), 32'd1);
    wait_idle(100);
    chk("t5_multi_vec", 32'(done_vec[done_vec.size()-1]), 32'd1);
    chk("t5_cnt1", 32'(cnt(1)), 32'd2);
    step();
    clr_flags = 1'b1;
    step();
    clr_flags = 1'b0;
    chk("t5_clr_perr", 32'(proto_err), 32'd0);
    n0 = done_cyc.size();
    step();
    irq = 1'b0; ack = 4'b1111;
    step();
    ack = 4'b0000;
    step();
    chk("t5_irq0_busy", 32'(busy), 32'd0);
    chk("t5_irq0_perr", 32'(proto_err), 32'd0);
    grant(4'b0000);
    chk("t5_zero_perr", 32'(proto_err), 32'd1);
    step();
    chk("t5_zero_busy", 32'(busy), 32'd0);
    chk("t5_zero_ndone", 32'(done_cyc.size() - n0), 32'd0);
    irq = 1'b1; ack = 4'b0000; clr_flags = 1'b1;
    step();
    irq = 1'b0; clr_flags = 1'b0;
    chk("t5_setwins", 32'(proto_err), 32'd1);
    clr_flags = 1'b1;
    step();
    clr_flags = 1'b0;
    chk("t5_clr2", 32'(proto_err), 32'd0);
    svc_len = 8'd0;
    grant(4'b1000);
    step();
    chk("t5_len0_valid", 32'(active_valid), 32'd1);
    chk("t5_len0_e1_done", 32'(done), 32'd0);
    step();
    chk("t5_len0_e2_done", 32'(done), 32'd1);
    step();
    chk("t5_len0_after", 32'(done), 32'd0);
    chk("t5_cnt3", 32'(cnt(3)), 32'd3);

    // 6a: reset during service
    svc_len = 8'd10;
    step();
    irq = 1'b1; ack = 4'b0100;
    step();
    ack = 4'b0001;
    step();
    irq = 1'b0; ack = 4'b0000;
    step();
    chk("t6_pre_valid", 32'(active_valid), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(active_valid), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_cnt", svc_count, 32'd0);
    n0 = done_cyc.size();
    step();
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 30; i++) step();
    chk("t6_no_done", 32'(done_cyc.size() - n0), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_cnt", svc_count, 32'd0);

    // 6b: saturation of source 1
    svc_len = 8'd1;
    for (int i = 1; i <= 300; i++) begin
      grant(4'b0010);
      wait_idle(20);
      if (i == 254) chk("t6_cnt254", 32'(cnt(1)), 32'd254);
      if (i == 255) chk("t6_cnt255", 32'(cnt(1)), 32'd255);
    end
    chk("t6_sat", 32'(cnt(1)), 32'd255);
    chk("t6_others", {cnt(3), cnt(2), cnt(0)}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
